// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D_RD = 2'd2,
        RSP_D_WR = 2'd3
    } rsp_state_t;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Winner select between fetch (I) and load/store (D) with a starvation
// counter that forces an I win after STARVE_LIMIT consecutive lost conflicts.
`timescale 1ns/1ps
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic d_valid,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_reg;
    logic [STARVE_CNT_W-1:0] cnt_next;
    logic                    starved;

    assign starved = (cnt_reg == LIMIT_C);

    // Nothing is granted while reset is held low.
    assign grant_i = reset && i_valid && (!d_valid || starved);
    assign grant_d = reset && d_valid && !(i_valid && starved);

    always_comb begin
        cnt_next = cnt_reg;
        if (!i_valid || grant_i) begin
            cnt_next = '0;
        end else if (grant_d && (cnt_reg < LIMIT_C)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch + load/store) arbiter onto one synchronous-read memory.
// Optional performance counters are built when ARB_PERF_COUNTERS_EN is defined.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ready,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_valid,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perf_i_grants,
    output logic [31:0]             perf_d_grants,
    output logic [31:0]             perf_conflicts
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic       grant_i;
    logic       grant_d;
    rsp_state_t rsp_reg;
    rsp_state_t rsp_next;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .d_valid (d_valid),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_ready = grant_i;
    assign d_ready = grant_d;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[ADDR_WIDTH-1:2];
            mem_wdata = d_wdata;
        end else if (grant_i) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[ADDR_WIDTH-1:2];
        end
    end

    // Byte enables are only live for a granted store.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wstrb
        assign mem_wstrb[gi] = grant_d && d_we && d_wstrb[gi];
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (grant_d) begin
            rsp_next = d_we ? RSP_D_WR : RSP_D_RD;
        end else if (grant_i) begin
            rsp_next = RSP_I;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_reg <= RSP_NONE;
        end else begin
            rsp_reg <= rsp_next;
        end
    end

    // Gating with reset drops a response that was in flight when reset hit.
    assign i_rvalid = reset && (rsp_reg == RSP_I);
    assign d_rvalid = reset && ((rsp_reg == RSP_D_RD) || (rsp_reg == RSP_D_WR));
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = (reset && (rsp_reg == RSP_D_RD)) ? mem_rdata : '0;

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] perf_i_reg;
    logic [31:0] perf_d_reg;
    logic [31:0] perf_c_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_i_reg <= '0;
            perf_d_reg <= '0;
            perf_c_reg <= '0;
        end else begin
            if (grant_i) perf_i_reg <= perf_i_reg + 32'd1;
            if (grant_d) perf_d_reg <= perf_d_reg + 32'd1;
            if (i_valid && d_valid) perf_c_reg <= perf_c_reg + 32'd1;
        end
    end

    assign perf_i_grants  = perf_i_reg;
    assign perf_d_grants  = perf_d_reg;
    assign perf_conflicts = perf_c_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants are checked as they are issued,
// expected responses are queued and matched by a response monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_valid;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0]   perf_i_grants;
    logic [31:0]   perf_d_grants;
    logic [31:0]   perf_conflicts;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_COUNTERS_EN
        ,
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro model and the bench's own reference image of its contents.
    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++)
                    if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    typedef struct {
        bit            is_i;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t sb[$];

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        rsp_t          e;
        logic [DW-1:0] got;
        logic [DW-1:0] other;
        #2;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_rsp: no rvalid at cycle %0d, required is_i=%0d data=%h", e.due, e.is_i, e.data);
        end
        if (i_rvalid || d_rvalid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_rsp: i_rvalid=%b d_rvalid=%b at cycle %0d, required none", i_rvalid, d_rvalid, cyc);
            end else begin
                e     = sb.pop_front();
                got   = e.is_i ? i_rdata : d_rdata;
                other = e.is_i ? d_rdata : i_rdata;
                if ({i_rvalid, d_rvalid} !== {e.is_i, !e.is_i} || got !== e.data ||
                    other !== '0 || e.due != cyc) begin
                    miscompares++;
                    $display("FAIL rsp_match: i_rvalid=%b d_rvalid=%b data=%h other=%h cycle=%0d, required is_i=%0d data=%h other=0 cycle=%0d",
                             i_rvalid, d_rvalid, got, other, cyc, e.is_i, e.data, e.due);
                end else begin
                    $display("rsp %s data=%h cycle=%0d", e.is_i ? "I" : "D", got, cyc);
                end
            end
        end
    end

    task automatic idle_inputs();
        i_valid = 1'b0;
        d_valid = 1'b0;
        d_we    = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        i_valid = 1'b1;
        i_addr  = 10'h010;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h020;
        d_wdata = '0;
        d_wstrb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({i_ready, d_ready, mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_grant: i_ready=%b d_ready=%b mem_en=%b, required 0 0 0", i_ready, d_ready, mem_en);
        end
        vectors++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_rvalid: i_rvalid=%b d_rvalid=%b, required 0 0", i_rvalid, d_rvalid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wstrb} !== '0) begin
            miscompares++;
            $display("FAIL idle_mem: en=%b we=%b addr=%h wstrb=%h, required all 0", mem_en, mem_we, mem_addr, mem_wstrb);
        end
    endtask

    task automatic test_fetch();
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_addr  = 10'h010;
        @(negedge clk);
        vectors++;
        if ({i_ready, d_ready, mem_en, mem_we} !== 4'b1010 || mem_addr !== 8'h04 || mem_wstrb !== '0) begin
            miscompares++;
            $display("FAIL fetch_grant: i_ready=%b d_ready=%b en=%b we=%b addr=%h wstrb=%h, required 1 0 1 0 004 0",
                     i_ready, d_ready, mem_en, mem_we, mem_addr, mem_wstrb);
        end
        sb.push_back('{1'b1, ref_mem[4], cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_store();
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h020;
        d_wdata = 32'hDEADBEEF;
        d_wstrb = 4'hF;
        @(negedge clk);
        vectors++;
        if ({d_ready, i_ready, mem_en, mem_we} !== 4'b1011 || mem_addr !== 8'h08 ||
            mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF) begin
            miscompares++;
            $display("FAIL store_grant: d_ready=%b i_ready=%b en=%b we=%b addr=%h wdata=%h wstrb=%h, required 1 0 1 1 008 deadbeef f",
                     d_ready, i_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        ref_mem[8] = 32'hDEADBEEF;
        sb.push_back('{1'b0, 32'h0, cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [9:0]    pat;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [AW-1:0] wa;
`ifdef ARB_PERF_COUNTERS_EN
        logic [31:0]   pi0, pd0, pc0;
`endif
        pat = 10'b10000_10000;   // bit c set: I wins in cycle c (D,D,D,D,I,D,D,D,D,I)
        ia  = 10'h100;
        da  = 10'h200;
        @(posedge clk);
        #1;
        idle_inputs();
`ifdef ARB_PERF_COUNTERS_EN
        @(negedge clk);
        pi0 = perf_i_grants;
        pd0 = perf_d_grants;
        pc0 = perf_conflicts;
`endif
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b1;
            i_addr  = ia;
            d_valid = 1'b1;
            d_we    = 1'b0;
            d_addr  = da;
            @(negedge clk);
            wa = pat[c] ? ia : da;
            vectors++;
            if (i_ready !== pat[c] || d_ready !== !pat[c] || mem_addr !== wa[AW-1:2]) begin
                miscompares++;
                $display("FAIL contention_c%0d: i_ready=%b d_ready=%b addr=%h, required %b %b %h",
                         c, i_ready, d_ready, mem_addr, pat[c], !pat[c], wa[AW-1:2]);
            end
            $display("contention cycle %0d winner=%s", c, pat[c] ? "I" : "D");
            if (pat[c]) begin
                sb.push_back('{1'b1, ref_mem[ia[AW-1:2]], cyc + 1});
                ia = ia + 10'd4;
            end else begin
                sb.push_back('{1'b0, ref_mem[da[AW-1:2]], cyc + 1});
                da = da + 10'd4;
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
`ifdef ARB_PERF_COUNTERS_EN
        vectors++;
        if (perf_d_grants - pd0 !== 32'd8 || perf_i_grants - pi0 !== 32'd2 || perf_conflicts - pc0 !== 32'd10) begin
            miscompares++;
            $display("FAIL perf_contention: d=%0d i=%0d conf=%0d, required 8 2 10",
                     perf_d_grants - pd0, perf_i_grants - pi0, perf_conflicts - pc0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] merged;
        // Load then fetch in consecutive cycles.
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h040;
        @(negedge clk);
        vectors++;
        if (d_ready !== 1'b1 || mem_addr !== 8'h10) begin
            miscompares++;
            $display("FAIL b2b_load: d_ready=%b addr=%h, required 1 010", d_ready, mem_addr);
        end
        sb.push_back('{1'b0, ref_mem[16], cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        i_valid = 1'b1;
        i_addr  = 10'h010;
        @(negedge clk);
        vectors++;
        if (i_ready !== 1'b1 || mem_addr !== 8'h04) begin
            miscompares++;
            $display("FAIL b2b_fetch: i_ready=%b addr=%h, required 1 004", i_ready, mem_addr);
        end
        sb.push_back('{1'b1, ref_mem[4], cyc + 1});
        // Partial store then fetch of the same word: fetch must see the store.
        @(posedge clk);
        #1;
        idle_inputs();
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h080;
        d_wdata = 32'hCAFEF00D;
        d_wstrb = 4'b0101;
        @(negedge clk);
        vectors++;
        if (d_ready !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0101) begin
            miscompares++;
            $display("FAIL b2b_store: d_ready=%b we=%b wstrb=%b, required 1 1 0101", d_ready, mem_we, mem_wstrb);
        end
        merged = ref_mem[32];
        merged[7:0]   = 8'h0D;
        merged[23:16] = 8'hFE;
        ref_mem[32]   = merged;
        sb.push_back('{1'b0, 32'h0, cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        i_valid = 1'b1;
        i_addr  = 10'h080;
        @(negedge clk);
        vectors++;
        if (i_ready !== 1'b1 || mem_addr !== 8'h20) begin
            miscompares++;
            $display("FAIL b2b_fetch2: i_ready=%b addr=%h, required 1 020", i_ready, mem_addr);
        end
        sb.push_back('{1'b1, ref_mem[32], cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h040;
        @(negedge clk);
        vectors++;
        if (d_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_grant: d_ready=%b, required 1", d_ready);
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        idle_inputs();
        i_valid = 1'b1;
        i_addr  = 10'h010;
        @(negedge clk);
        vectors++;
        if ({d_rvalid, i_ready, mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL inflight_drop: d_rvalid=%b i_ready=%b mem_en=%b, required 0 0 0", d_rvalid, i_ready, mem_en);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef ARB_PERF_COUNTERS_EN
        vectors++;
        if ({perf_i_grants, perf_d_grants, perf_conflicts} !== '0) begin
            miscompares++;
            $display("FAIL perf_reset: i=%0d d=%0d conf=%0d, required 0 0 0", perf_i_grants, perf_d_grants, perf_conflicts);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (i_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 8'h04) begin
            miscompares++;
            $display("FAIL post_reset_fetch: i_ready=%b en=%b addr=%h, required 1 1 004", i_ready, mem_en, mem_addr);
        end
        sb.push_back('{1'b1, ref_mem[4], cyc + 1});
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int w = 0; w < 256; w++) begin
            mem_arr[w] = {w[7:0], 8'hA5, ~w[7:0], 8'h3C};
            ref_mem[w] = {w[7:0], 8'hA5, ~w[7:0], 8'h3C};
        end
        mem_arr[4]  = 32'h00000013;
        ref_mem[4]  = 32'h00000013;
        mem_arr[16] = 32'h12345678;
        ref_mem[16] = 32'h12345678;

        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_back_to_back();
        test_reset_inflight();

        repeat (3) @(negedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
